// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - per-bit persistence filter with edge pulses and saturating event counter
//
// Each bit of d must differ from its filtered level q for FILT_LEN consecutive
// enabled cycles before q follows it. A bit's state is held in q[i] plus a
// private run counter cnt[i]; the four states are q=0/1 combined with cnt=0
// (stable) or cnt>0 (pending).
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   d        in   [DSIZE] inputs, already synchronous to clk
//   en       in   filter enable; 0 freezes all state
//   clr      in   synchronous clear of evt_cnt
//   q        out  [DSIZE] filtered levels
//   rise     out  [DSIZE] one-cycle pulse when q[i] goes 0->1
//   fall     out  [DSIZE] one-cycle pulse when q[i] goes 1->0
//   evt_cnt  out  [ECW] saturating count of cycles with any rise/fall pulse

module sync_edge_filter #(
    parameter int DSIZE    = 1,
    parameter int FILT_LEN = 4,
    parameter int ECW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] d,
    input  logic             en,
    input  logic             clr,
    output logic [DSIZE-1:0] q,
    output logic [DSIZE-1:0] rise,
    output logic [DSIZE-1:0] fall,
    output logic [ECW-1:0]   evt_cnt
);

    localparam int CW = $clog2(FILT_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] cnt [DSIZE];
    logic          any_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < DSIZE; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // Pulses default low; they are only raised on the edge q changes.
            rise <= '0;
            fall <= '0;
            if (en) begin
                for (int i = 0; i < DSIZE; i++) begin
                    if (d[i] == q[i]) begin
                        // Input agrees with output: any pending run is a glitch.
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        // This is the FILT_LEN-th consecutive differing sample.
                        q[i]    <= d[i];
                        cnt[i]  <= '0;
                        rise[i] <= d[i];
                        fall[i] <= q[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    // Counts the registered pulses, so evt_cnt lags rise/fall by one cycle.
    assign any_evt = (|rise) | (|fall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (clr) begin
            evt_cnt <= '0;
        end else if (en && any_evt && (evt_cnt != {ECW{1'b1}})) begin
            evt_cnt <= evt_cnt + ECW'(1);
        end
    end

endmodule

// File: tb/tb_sync_edge_filter.sv
// tb/tb_sync_edge_filter.sv - directed scoreboard bench for sync_edge_filter

module tb_sync_edge_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  d   = 2'b00;
    logic        en  = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  q, rise, fall;
    logic [15:0] evt_cnt;

    logic        srst = 1'b0;
    logic        sd   = 1'b0;
    logic        sen  = 1'b1;
    logic        sclr = 1'b0;
    logic        sq, srise, sfall;
    logic [1:0]  sevt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [1:0]  q;
        logic [1:0]  rise;
        logic [1:0]  fall;
        logic [15:0] evt;
    } exp_t;

    exp_t sb[$];

    sync_edge_filter #(.DSIZE(2), .FILT_LEN(4), .ECW(16)) u_dut (
        .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
        .q(q), .rise(rise), .fall(fall), .evt_cnt(evt_cnt)
    );

    sync_edge_filter #(.DSIZE(1), .FILT_LEN(1), .ECW(2)) u_sat (
        .clk(clk), .rst(srst), .d(sd), .en(sen), .clr(sclr),
        .q(sq), .rise(srise), .fall(sfall), .evt_cnt(sevt)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [1:0] eq, input logic [1:0] er,
                            input logic [1:0] ef, input logic [15:0] ee);
        exp_t e;
        e.tag  = tag;
        e.q    = eq;
        e.rise = er;
        e.fall = ef;
        e.evt  = ee;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input logic [1:0] oq, input logic [1:0] orise,
                           input logic [1:0] ofall, input logic [15:0] oevt);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".q"},    16'(oq),    16'(e.q));
            cmp({e.tag, ".rise"}, 16'(orise), 16'(e.rise));
            cmp({e.tag, ".fall"}, 16'(ofall), 16'(e.fall));
            cmp({e.tag, ".evt"},  oevt,       e.evt);
        end
    endtask

    // Drive main DUT inputs, expect outputs after the next rising edge.
    task automatic step_m(input logic [1:0] vd, input logic ven, input logic vclr,
                          input logic [1:0] eq, input logic [1:0] er, input logic [1:0] ef,
                          input logic [15:0] ee, input string tag);
        d   = vd;
        en  = ven;
        clr = vclr;
        push_exp(tag, eq, er, ef, ee);
        @(posedge clk);
        #1;
        pop_cmp(q, rise, fall, evt_cnt);
    endtask

    task automatic step_s(input logic vd, input logic vclr,
                          input logic eq, input logic er, input logic ef,
                          input logic [1:0] ee, input string tag);
        sd   = vd;
        sclr = vclr;
        push_exp(tag, {1'b0, eq}, {1'b0, er}, {1'b0, ef}, 16'(ee));
        @(posedge clk);
        #1;
        pop_cmp({1'b0, sq}, {1'b0, srise}, {1'b0, sfall}, 16'(sevt));
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #1;
        rst  = 1'b1;
        srst = 1'b1;
        d    = 2'b01;
        push_exp("reset_async", 2'b00, 2'b00, 2'b00, 16'd0);
        #1;
        pop_cmp(q, rise, fall, evt_cnt);
        push_exp("sat_reset", 2'b00, 2'b00, 2'b00, 16'd0);
        pop_cmp({1'b0, sq}, {1'b0, srise}, {1'b0, sfall}, 16'(sevt));

        @(posedge clk);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        srst = 1'b0;

        // d bit0 already high at reset release still needs 4 edges.
        step_m(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "rise_e1");
        step_m(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "rise_e2");
        step_m(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "rise_e3");
        step_m(2'b01, 1, 0, 2'b01, 2'b01, 2'b00, 16'd0, "rise_e4");
        step_m(2'b01, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "rise_e5");

        // Two 3-cycle glitches on bit1; the second proves the count was cleared.
        for (int g = 0; g < 2; g++) begin
            step_m(2'b11, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "glitch_a");
            step_m(2'b11, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "glitch_b");
            step_m(2'b11, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "glitch_c");
            step_m(2'b01, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "glitch_end");
        end

        // Bit0 falls.
        step_m(2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "fall_e1");
        step_m(2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "fall_e2");
        step_m(2'b00, 1, 0, 2'b01, 2'b00, 2'b00, 16'd1, "fall_e3");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b01, 16'd1, "fall_e4");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 16'd2, "fall_e5");

        // Both bits rise together: one event.
        step_m(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 16'd2, "dual_e1");
        step_m(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 16'd2, "dual_e2");
        step_m(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 16'd2, "dual_e3");
        step_m(2'b11, 1, 0, 2'b11, 2'b11, 2'b00, 16'd2, "dual_e4");
        step_m(2'b11, 1, 0, 2'b11, 2'b00, 2'b00, 16'd3, "dual_e5");

        // Freeze mid-pending with cnt=2, then resume: q changes 2 edges later.
        step_m(2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 16'd3, "freeze_p1");
        step_m(2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 16'd3, "freeze_p2");
        for (int k = 0; k < 5; k++) begin
            step_m(2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 16'd3, "freeze_hold");
        end
        step_m(2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 16'd3, "resume_e1");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b11, 16'd3, "resume_e2");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 16'd4, "resume_e3");

        // Clear of the event counter.
        step_m(2'b00, 1, 1, 2'b00, 2'b00, 2'b00, 16'd0, "clr");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "clr_after");

        // Raise both, then start a fall and reset mid-pending.
        step_m(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "pre_rst_e1");
        step_m(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "pre_rst_e2");
        step_m(2'b11, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "pre_rst_e3");
        step_m(2'b11, 1, 0, 2'b11, 2'b11, 2'b00, 16'd0, "pre_rst_e4");
        step_m(2'b11, 1, 0, 2'b11, 2'b00, 2'b00, 16'd1, "pre_rst_e5");
        step_m(2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 16'd1, "pend_fall1");
        step_m(2'b00, 1, 0, 2'b11, 2'b00, 2'b00, 16'd1, "pend_fall2");
        #2;
        rst = 1'b1;
        push_exp("rst_mid_pend", 2'b00, 2'b00, 2'b00, 16'd0);
        #1;
        pop_cmp(q, rise, fall, evt_cnt);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "post_rst_e1");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "post_rst_e2");
        step_m(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 16'd0, "post_rst_e3");

        // FILT_LEN=1 register behaviour and ECW=2 saturation.
        step_s(1, 0, 1, 1, 0, 2'd0, "sat_e1");
        step_s(0, 0, 0, 0, 1, 2'd1, "sat_e2");
        step_s(1, 0, 1, 1, 0, 2'd2, "sat_e3");
        step_s(0, 0, 0, 0, 1, 2'd3, "sat_e4");
        step_s(1, 0, 1, 1, 0, 2'd3, "sat_e5");
        step_s(0, 0, 0, 0, 1, 2'd3, "sat_e6");
        step_s(1, 1, 1, 1, 0, 2'd0, "sat_clr_evt");
        step_s(1, 0, 1, 0, 0, 2'd1, "sat_after_clr");
        step_s(1, 0, 1, 0, 0, 2'd1, "sat_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_edge_filter.md
SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

Interface
REQ-001 Parameter DSIZE, 1, number of independent filtered bits (>=1).
REQ-002 Parameter FILT_LEN, 4, consecutive cycles a differing input must persist before the output follows (>=1).
REQ-003 Parameter ECW, 16, width of the event counter (>=2).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port d  input  DSIZE  already-synchronized level inputs from the upstream cross-clock synchronizer stage.
REQ-007 Port en  input  1  filter enable; 0 freezes all state.
REQ-008 Port clr  input  1  synchronous clear of evt_cnt only.
REQ-009 Port q  output  DSIZE  filtered levels, registered.
REQ-010 Port rise  output  DSIZE  one-cycle pulse per bit when q[i] goes 0->1, registered.
REQ-011 Port fall  output  DSIZE  one-cycle pulse per bit when q[i] goes 1->0, registered.
REQ-012 Port evt_cnt  output  ECW  saturating count of cycles in which any bit of rise or fall was asserted.

Function
REQ-013 Each bit i SHALL have a private counter cnt[i] of width ceil(log2(FILT_LEN))+1, invisible at ports.
REQ-014 Per-bit state SHALL be one of: LO_STABLE (q=0,cnt=0), LO_PEND (q=0,cnt>0), HI_STABLE (q=1,cnt=0), HI_PEND (q=1,cnt>0).
REQ-015 With en=1 and d[i]==q[i], cnt[i] SHALL clear to 0 (PEND -> STABLE, the output does not change).
REQ-016 With en=1, d[i]!=q[i] and cnt[i]<FILT_LEN-1, cnt[i] SHALL increment (STABLE -> PEND or remain PEND).
REQ-017 With en=1, d[i]!=q[i] and cnt[i]==FILT_LEN-1, q[i] SHALL load d[i] and cnt[i] SHALL clear (transition to the opposite STABLE state).
REQ-018 Latency: a d[i] change first sampled at edge t and held stable SHALL appear on q[i] after edge t+FILT_LEN-1, i.e. FILT_LEN cycles after first sampling; with FILT_LEN=1, q is a plain one-cycle register of d.
REQ-019 A glitch shorter than FILT_LEN sampled cycles SHALL NOT change q[i] and SHALL leave cnt[i]=0 once d[i] returns to q[i].
REQ-020 rise[i]/fall[i] SHALL assert in the same cycle q[i] presents its new value, for exactly one cycle, and SHALL be 0 otherwise.
REQ-021 Bits SHALL be fully independent; simultaneous transitions on several bits SHALL each pulse.
REQ-022 With en=0, q and cnt SHALL hold, and rise, fall and evt_cnt increments SHALL be 0.
REQ-023 evt_cnt SHALL increment by 1 on each edge where the registered (|rise)|(|fall) is 1, saturating at 2^ECW-1 without wrapping.
REQ-024 clr=1 SHALL set evt_cnt to 0 at the next edge; clr takes priority over a coincident increment.
REQ-025 The block SHALL NOT add extra synchronizer flops; d is treated as already synchronous to clk.

Reset
REQ-026 rst=1 SHALL immediately force q=0, rise=0, fall=0, evt_cnt=0 and all cnt=0 (all bits LO_STABLE), independent of clk.
REQ-027 After rst deasserts, a d bit already at 1 SHALL still need FILT_LEN cycles to reach q; no pulse is skipped.
REQ-028 Reset asserted while a bit is in PEND SHALL discard the pending count with no pulse emitted.

Verification
REQ-029 DSIZE=1, FILT_LEN=4: d 0->1 held -> q=1 and rise=1 on the 4th edge after the change, evt_cnt=1.
REQ-030 FILT_LEN=4: d high for 3 cycles then low -> q stays 0, no rise pulse, evt_cnt stays 0.
REQ-031 DSIZE=2: both bits 0->1 in the same cycle -> rise=2'b11 for one cycle, evt_cnt increments by 1 only.
REQ-032 en=0 for 5 cycles mid-PEND (cnt=2) -> q holds, cnt holds; after en=1, q changes 2 cycles later.
REQ-033 ECW=2: 5 edge events -> evt_cnt saturates at 3; clr coincident with an event -> evt_cnt=0.
REQ-034 rst pulsed while q=1 and a fall is pending -> q=0 immediately, no fall pulse, evt_cnt=0.
